vga_sync_gen: RTL and testbench

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

---
 rtl/vga_timing_pkg.sv | 38 +++
 rtl/pixel_tick_gen.sv | 35 +++
 rtl/vga_sync_gen.sv | 98 +++++++++
 tb/tb_vga_sync_gen.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing definitions. The sync generator and the later
// pixel/colour stage both import this package.
// Contents: default 640x480@60 timing, derived line/frame totals, the
// sync polarity and a small window-decode helper.
package vga_timing_pkg;

  localparam int COORD_W      = 10;

  localparam int DEF_CLK_DIV  = 2;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // Both sync pulses are active-low for this mode.
  localparam logic SYNC_ACTIVE = 1'b0;

  // Total length of a line (pixels) or a frame (lines).
  function automatic int span_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  localparam int DEF_H_TOTAL = span_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int DEF_V_TOTAL = span_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

  // Inclusive range test on a coordinate.
  function automatic logic in_window(input logic [COORD_W-1:0] v,
                                     input logic [COORD_W-1:0] lo,
                                     input logic [COORD_W-1:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// Pixel-strobe divider. The counter runs 0..CLK_DIV-1 and wraps.
// The strobe is registered, so it is high for the one clock cycle that
// follows the edge on which the counter wraps. With CLK_DIV=1 the
// counter never leaves 0, so the strobe stays high after reset.
// Ports:
//   clk   in  1  clock, rising edge
//   rst_n in  1  asynchronous active-low reset
//   tick  out 1  one-cycle pixel strobe
module pixel_tick_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             div_wrap;

  assign div_wrap = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      div_cnt <= div_wrap ? '0 : div_cnt + DIV_W'(1);
      tick    <= div_wrap;
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync generator: pixel/line counters and sync/blanking decode.
// The counters reset to the last position of the frame. The first
// pixel advance therefore wraps to (0,0) and raises FRAME_START.
// HSYNC, VSYNC, VIDEO_ON and FRAME_START are decoded from the
// next-state counter values and registered on the same edge as the
// counters. They line up with PIX_X/PIX_Y and cannot glitch.
// Ports:
//   CLK_IN      in  1   sole clock, rising edge
//   RESET_N     in  1   asynchronous active-low reset
//   PIX_TICK    out 1   one-cycle pixel strobe
//   PIX_X       out 10  horizontal counter (includes blanking)
//   PIX_Y       out 10  vertical counter (includes blanking)
//   HSYNC       out 1   horizontal sync, active-low
//   VSYNC       out 1   vertical sync, active-low
//   VIDEO_ON    out 1   high inside the visible area
//   FRAME_START out 1   one-cycle pulse on the first cycle at (0,0)
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic               CLK_IN,
  input  logic               RESET_N,
  output logic               PIX_TICK,
  output logic [COORD_W-1:0] PIX_X,
  output logic [COORD_W-1:0] PIX_Y,
  output logic               HSYNC,
  output logic               VSYNC,
  output logic               VIDEO_ON,
  output logic               FRAME_START
);

  localparam int H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [COORD_W-1:0] H_LAST    = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST    = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_VIS     = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_VIS     = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] H_SYNC_LO = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] H_SYNC_HI = COORD_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [COORD_W-1:0] V_SYNC_LO = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] V_SYNC_HI = COORD_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [COORD_W-1:0] x_next;
  logic [COORD_W-1:0] y_next;
  logic               h_wrap;

  pixel_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk   (CLK_IN),
    .rst_n (RESET_N),
    .tick  (PIX_TICK)
  );

  // Next counter position. It only moves on a cycle where the strobe is high.
  always_comb begin
    h_wrap = (PIX_X == H_LAST);
    x_next = PIX_X;
    y_next = PIX_Y;
    if (PIX_TICK) begin
      x_next = h_wrap ? '0 : PIX_X + COORD_W'(1);
      if (h_wrap) begin
        y_next = (PIX_Y == V_LAST) ? '0 : PIX_Y + COORD_W'(1);
      end
    end
  end

  always_ff @(posedge CLK_IN or negedge RESET_N) begin
    if (!RESET_N) begin
      PIX_X       <= H_LAST;
      PIX_Y       <= V_LAST;
      HSYNC       <= ~SYNC_ACTIVE;
      VSYNC       <= ~SYNC_ACTIVE;
      VIDEO_ON    <= 1'b0;
      FRAME_START <= 1'b0;
    end else begin
      PIX_X       <= x_next;
      PIX_Y       <= y_next;
      HSYNC       <= in_window(x_next, H_SYNC_LO, H_SYNC_HI) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      VSYNC       <= in_window(y_next, V_SYNC_LO, V_SYNC_HI) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      VIDEO_ON    <= (x_next < H_VIS) && (y_next < V_VIS);
      // The strobe-gated step into (0,0) is the only way to enter the
      // first pixel. That entry is the frame's first cycle there.
      FRAME_START <= PIX_TICK && h_wrap && (PIX_Y == V_LAST);
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen. It uses three instances:
//   a: default 640x480 timing, CLK_DIV=2
//   b: reduced timing (16x10 totals), CLK_DIV=2, for whole-frame and
//      mid-frame reset behaviour
//   c: default timing, CLK_DIV=4
module tb_vga_sync_gen;

  logic clk = 1'b0;
  logic rst_n;
  logic rst_b_n;

  always #5 clk = ~clk;

  logic       a_tick, a_hs, a_vs, a_von, a_fs;
  logic [9:0] a_x, a_y;
  logic       b_tick, b_hs, b_vs, b_von, b_fs;
  logic [9:0] b_x, b_y;
  logic       c_tick, c_hs, c_vs, c_von, c_fs;
  logic [9:0] c_x, c_y;

  vga_sync_gen u_a (
    .CLK_IN(clk), .RESET_N(rst_n), .PIX_TICK(a_tick), .PIX_X(a_x), .PIX_Y(a_y),
    .HSYNC(a_hs), .VSYNC(a_vs), .VIDEO_ON(a_von), .FRAME_START(a_fs)
  );

  vga_sync_gen #(
    .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) u_b (
    .CLK_IN(clk), .RESET_N(rst_b_n), .PIX_TICK(b_tick), .PIX_X(b_x), .PIX_Y(b_y),
    .HSYNC(b_hs), .VSYNC(b_vs), .VIDEO_ON(b_von), .FRAME_START(b_fs)
  );

  vga_sync_gen #(.CLK_DIV(4)) u_c (
    .CLK_IN(clk), .RESET_N(rst_n), .PIX_TICK(c_tick), .PIX_X(c_x), .PIX_Y(c_y),
    .HSYNC(c_hs), .VSYNC(c_vs), .VIDEO_ON(c_von), .FRAME_START(c_fs)
  );

  int errors = 0;
  int checks = 0;
  int n;

  // previous-cycle copies
  int   a_px, a_py, b_px, b_py, c_px, c_py;
  logic a_ptick, b_ptick, c_ptick, a_phs, c_phs, b_pfs;

  // measurements
  int a_tick_bad, b_tick_bad, c_tick_bad;
  int a_cnt_bad, b_cnt_bad, c_cnt_bad;
  int a_dec_bad, b_dec_bad, c_dec_bad;
  int a_wraps, a_w1, a_w2, a_hs_low, a_fall_x;
  int c_wraps, c_w1, c_w2, c_hs_low, c_fall_x;
  int b_fs_n, b_fs1, b_fs2, b_fs_bad, b_vs_low, b_vid;
  logic found;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic capture();
    a_px = int'(a_x); a_py = int'(a_y); a_ptick = a_tick; a_phs = a_hs;
    b_px = int'(b_x); b_py = int'(b_y); b_ptick = b_tick; b_pfs = b_fs;
    c_px = int'(c_x); c_py = int'(c_y); c_ptick = c_tick; c_phs = c_hs;
  endtask

  // Independent counter model: position expected after one cycle.
  function automatic int cnt_bad(int px, int py, logic ptick, int x, int y, int ht, int vt);
    int ex = px;
    int ey = py;
    if (ptick) begin
      ex = (px == ht - 1) ? 0 : px + 1;
      if (px == ht - 1) ey = (py == vt - 1) ? 0 : py + 1;
    end
    return (x != ex || y != ey) ? 1 : 0;
  endfunction

  // Independent decode model of sync and blanking from the coordinates.
  function automatic int dec_bad(int x, int y, logic hs, logic vs, logic von,
                                 int ha, int hfp, int hsy, int va, int vfp, int vsy);
    logic ehs  = !(x >= ha + hfp && x < ha + hfp + hsy);
    logic evs  = !(y >= va + vfp && y < va + vfp + vsy);
    logic evon = (x < ha) && (y < va);
    return (hs !== ehs || vs !== evs || von !== evon) ? 1 : 0;
  endfunction

  initial begin
    {a_tick_bad, b_tick_bad, c_tick_bad} = '0;
    {a_cnt_bad, b_cnt_bad, c_cnt_bad} = '0;
    {a_dec_bad, b_dec_bad, c_dec_bad} = '0;
    {a_wraps, a_w1, a_w2, a_hs_low, a_fall_x} = '0;
    {c_wraps, c_w1, c_w2, c_hs_low, c_fall_x} = '0;
    {b_fs_n, b_fs1, b_fs2, b_fs_bad, b_vs_low, b_vid} = '0;
    a_fall_x = -1;
    c_fall_x = -1;
    found = 1'b0;

    // asynchronous reset, applied before the first clock edge
    rst_n = 1'b1; rst_b_n = 1'b1;
    #1;
    rst_n = 1'b0; rst_b_n = 1'b0;
    #1;
    chk("rst_tick", a_tick, 0);
    chk("rst_x", a_x, 799);
    chk("rst_y", a_y, 524);
    chk("rst_hsync", a_hs, 1);
    chk("rst_vsync", a_vs, 1);
    chk("rst_video_on", a_von, 0);
    chk("rst_frame_start", a_fs, 0);
    chk("rst_b_x", b_x, 15);
    chk("rst_b_y", b_y, 9);

    repeat (2) @(negedge clk);
    rst_n = 1'b1; rst_b_n = 1'b1;
    n = 0;

    step(); n++;                       // edge 1
    chk("e1_tick", a_tick, 0);
    chk("e1_x_hold", a_x, 799);
    step(); n++;                       // edge 2
    chk("e2_tick", a_tick, 1);
    chk("e2_x_hold", a_x, 799);
    chk("e2_fs", a_fs, 0);
    step(); n++;                       // edge 3
    chk("e3_x", a_x, 0);
    chk("e3_y", a_y, 0);
    chk("e3_video_on", a_von, 1);
    chk("e3_fs", a_fs, 1);
    chk("e3_hsync", a_hs, 1);
    chk("e3_vsync", a_vs, 1);
    chk("e3_c_tick", c_tick, 0);
    chk("e3_c_x", c_x, 799);
    step(); n++;                       // edge 4
    chk("e4_fs_one_cycle", a_fs, 0);
    chk("e4_x_hold", a_x, 0);
    chk("e4_c_tick", c_tick, 1);
    capture();

    // free-running observation over several lines and many small frames
    for (int i = 0; i < 6600; i++) begin
      step(); n++;
      if (a_tick !== ((n % 2) == 0)) a_tick_bad++;
      if (b_tick !== ((n % 2) == 0)) b_tick_bad++;
      if (c_tick !== ((n % 4) == 0)) c_tick_bad++;
      a_cnt_bad += cnt_bad(a_px, a_py, a_ptick, int'(a_x), int'(a_y), 800, 525);
      b_cnt_bad += cnt_bad(b_px, b_py, b_ptick, int'(b_x), int'(b_y), 16, 10);
      c_cnt_bad += cnt_bad(c_px, c_py, c_ptick, int'(c_x), int'(c_y), 800, 525);
      a_dec_bad += dec_bad(int'(a_x), int'(a_y), a_hs, a_vs, a_von, 640, 16, 96, 480, 10, 2);
      b_dec_bad += dec_bad(int'(b_x), int'(b_y), b_hs, b_vs, b_von, 8, 2, 3, 6, 1, 2);
      c_dec_bad += dec_bad(int'(c_x), int'(c_y), c_hs, c_vs, c_von, 640, 16, 96, 480, 10, 2);

      if (a_px == 799 && a_x == 0) begin
        a_wraps++;
        if (a_wraps == 1) a_w1 = n;
        if (a_wraps == 2) a_w2 = n;
      end
      if (a_wraps == 1 && !a_hs) a_hs_low++;
      if (a_phs && !a_hs && a_fall_x < 0) a_fall_x = int'(a_x);

      if (c_px == 799 && c_x == 0) begin
        c_wraps++;
        if (c_wraps == 1) c_w1 = n;
        if (c_wraps == 2) c_w2 = n;
      end
      if (c_wraps == 1 && !c_hs) c_hs_low++;
      if (c_phs && !c_hs && c_fall_x < 0) c_fall_x = int'(c_x);

      if (b_fs) begin
        if (b_pfs || b_x != 0 || b_y != 0) b_fs_bad++;
        b_fs_n++;
        if (b_fs_n == 1) begin
          b_fs1 = n;
          chk("b_wrap_from_x", b_px, 15);
          chk("b_wrap_from_y", b_py, 9);
        end
        if (b_fs_n == 2) b_fs2 = n;
      end
      if (b_fs_n == 1) begin
        if (!b_vs) b_vs_low++;
        if (b_tick && b_von) b_vid++;
      end
      capture();
    end

    chk("a_tick_pattern", a_tick_bad, 0);
    chk("a_counter_steps", a_cnt_bad, 0);
    chk("a_decode", a_dec_bad, 0);
    chk("a_line_period", a_w2 - a_w1, 1600);
    chk("a_hsync_width", a_hs_low, 192);
    chk("a_hsync_fall_x", a_fall_x, 656);
    chk("b_tick_pattern", b_tick_bad, 0);
    chk("b_counter_steps", b_cnt_bad, 0);
    chk("b_decode", b_dec_bad, 0);
    chk("b_frame_period", b_fs2 - b_fs1, 320);
    chk("b_frame_count", b_fs_n, 20);
    chk("b_fs_shape", b_fs_bad, 0);
    chk("b_vsync_width", b_vs_low, 64);
    chk("b_visible_pixels", b_vid, 48);
    chk("c_tick_pattern", c_tick_bad, 0);
    chk("c_counter_steps", c_cnt_bad, 0);
    chk("c_decode", c_dec_bad, 0);
    chk("c_line_period", c_w2 - c_w1, 3200);
    chk("c_hsync_width", c_hs_low, 384);
    chk("c_hsync_fall_x", c_fall_x, 656);

    // mid-frame reset of instance b between clock edges
    for (int k = 0; k < 400 && !found; k++) begin
      step();
      if (b_x == 5 && b_y == 3) found = 1'b1;
    end
    chk("b_reach_mid_frame", found, 1);
    chk("b_mid_video_on", b_von, 1);
    @(negedge clk);
    #2;
    rst_b_n = 1'b0;
    #1;
    chk("mid_rst_tick", b_tick, 0);
    chk("mid_rst_x", b_x, 15);
    chk("mid_rst_y", b_y, 9);
    chk("mid_rst_hsync", b_hs, 1);
    chk("mid_rst_vsync", b_vs, 1);
    chk("mid_rst_video_on", b_von, 0);
    chk("mid_rst_fs", b_fs, 0);
    repeat (2) @(negedge clk);
    rst_b_n = 1'b1;
    step();
    chk("re_e1_tick", b_tick, 0);
    step();
    chk("re_e2_tick", b_tick, 1);
    chk("re_e2_x", b_x, 15);
    step();
    chk("re_e3_x", b_x, 0);
    chk("re_e3_y", b_y, 0);
    chk("re_e3_fs", b_fs, 1);
    chk("re_e3_video_on", b_von, 1);
    step();
    chk("re_e4_fs", b_fs, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
